// File: rtl/loader_pkg.sv
// Shared types and constants for the boot-time instruction memory loader.
package loader_pkg;

    typedef enum logic [2:0] {
        LEN0,
        LEN1,
        DATA,
        CSUM,
        RUN,
        FAIL
    } state_t;

    localparam int LEN_BYTES  = 2;
    localparam int WORD_BYTES = 4;

endpackage

// File: rtl/byte_packer.sv
// Packs accepted stream bytes into 32-bit little-endian words and flags each
// completed word with a one-cycle word_valid alongside the registered word.
module byte_packer
    import loader_pkg::*;
(
    input  logic        clk,
    input  logic        rstn,
    input  logic        byte_valid,
    input  logic [7:0]  byte_data,
    output logic [1:0]  byte_idx,
    output logic        word_valid,
    output logic [31:0] word_data
);

    logic [23:0] low_bytes;
    logic        last_byte;

    assign last_byte = byte_valid && (byte_idx == 2'(WORD_BYTES - 1));

    // Earlier bytes shift down so byte 0 of the word lands in bits [7:0].
    always_ff @(posedge clk) begin
        if (!rstn) begin
            byte_idx   <= '0;
            low_bytes  <= '0;
            word_valid <= 1'b0;
            word_data  <= '0;
        end else begin
            word_valid <= last_byte;
            if (byte_valid) begin
                byte_idx  <= 2'(byte_idx + 2'd1);
                low_bytes <= {byte_data, low_bytes[23:8]};
            end
            if (last_byte) begin
                word_data <= {byte_data, low_bytes};
            end
        end
    end

endmodule

// File: rtl/imem_loader.sv
// Boot loader: receives a length-prefixed, XOR-checksummed byte stream, writes it
// into instruction memory and holds the core in reset until the image verifies.
module imem_loader
    import loader_pkg::*;
#(
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              cpu_rstn,
    output logic              load_done,
    output logic              load_error
);

    localparam int DEPTH = 2 ** ADDR_W;
    localparam int LEN_W = 8 * LEN_BYTES;

    state_t            state;
    state_t            state_next;
    logic [LEN_W-1:0]  len;
    logic [7:0]        csum;
    logic [ADDR_W:0]   word_cnt;
    logic              accept;
    logic              data_byte;
    logic [1:0]        byte_idx;
    logic              word_valid;
    logic [31:0]       word_data;

    assign accept    = in_valid && in_ready;
    assign data_byte = accept && (state == DATA);

    byte_packer u_packer (
        .clk        (clk),
        .rstn       (rstn),
        .byte_valid (data_byte),
        .byte_data  (in_data),
        .byte_idx   (byte_idx),
        .word_valid (word_valid),
        .word_data  (word_data)
    );

    assign imem_we    = word_valid;
    assign imem_wdata = word_data;
    assign imem_addr  = word_cnt[ADDR_W-1:0];

    always_comb begin
        state_next = state;
        case (state)
            LEN0: if (accept) state_next = LEN1;
            LEN1: begin
                if (accept) begin
                    if ({1'b0, in_data, len[7:0]} > 17'(DEPTH)) begin
                        state_next = FAIL;
                    end else if ({in_data, len[7:0]} == '0) begin
                        state_next = CSUM;
                    end else begin
                        state_next = DATA;
                    end
                end
            end
            // word_cnt still holds the current word's index when its last byte arrives.
            DATA: begin
                if (data_byte && (byte_idx == 2'(WORD_BYTES - 1)) &&
                    (17'(word_cnt) + 17'd1 == {1'b0, len})) begin
                    state_next = CSUM;
                end
            end
            CSUM: if (accept) state_next = (in_data == csum) ? RUN : FAIL;
            default: state_next = state;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state      <= LEN0;
            len        <= '0;
            csum       <= '0;
            word_cnt   <= '0;
            in_ready   <= 1'b0;
            cpu_rstn   <= 1'b0;
            load_done  <= 1'b0;
            load_error <= 1'b0;
        end else begin
            state <= state_next;
            if (accept && (state == LEN0)) len[7:0] <= in_data;
            if (accept && (state == LEN1)) len[15:8] <= in_data;
            if (data_byte) csum <= csum ^ in_data;
            if (word_valid) word_cnt <= word_cnt + {{ADDR_W{1'b0}}, 1'b1};
            in_ready   <= (state_next == LEN0) || (state_next == LEN1) ||
                          (state_next == DATA) || (state_next == CSUM);
            cpu_rstn   <= (state_next == RUN);
            load_done  <= (state_next == RUN);
            load_error <= (state_next == FAIL);
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Randomised self-checking bench for imem_loader with a stream-level reference model;
// one instance at the default depth and one shallow instance for the length limits.
module tb_imem_loader;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rstn     = 1'b0;
    logic       in_valid = 1'b0;
    logic [7:0] in_data  = 8'h00;

    logic        ready_b, we_b, cpu_b, done_b, err_b;
    logic [9:0]  addr_b;
    logic [31:0] wdata_b;
    logic        ready_s, we_s, cpu_s, done_s, err_s;
    logic [1:0]  addr_s;
    logic [31:0] wdata_s;

    imem_loader #(.ADDR_W(10)) dut_big (
        .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_data(in_data),
        .in_ready(ready_b), .imem_we(we_b), .imem_addr(addr_b), .imem_wdata(wdata_b),
        .cpu_rstn(cpu_b), .load_done(done_b), .load_error(err_b)
    );

    imem_loader #(.ADDR_W(2)) dut_small (
        .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_data(in_data),
        .in_ready(ready_s), .imem_we(we_s), .imem_addr(addr_s), .imem_wdata(wdata_s),
        .cpu_rstn(cpu_s), .load_done(done_s), .load_error(err_s)
    );

    bit          sel_small = 1'b0;
    logic        rdy, we, cpu, done, err;
    logic [9:0]  addr;
    logic [31:0] wdata;

    assign rdy   = sel_small ? ready_s : ready_b;
    assign we    = sel_small ? we_s : we_b;
    assign cpu   = sel_small ? cpu_s : cpu_b;
    assign done  = sel_small ? done_s : done_b;
    assign err   = sel_small ? err_s : err_b;
    assign addr  = sel_small ? {8'b0, addr_s} : addr_b;
    assign wdata = sel_small ? wdata_s : wdata_b;

    int          checks = 0;
    int          errors = 0;
    logic [7:0]  stream[$];
    logic [41:0] exp_wr[$];
    logic [41:0] wr_log[$];
    int          exp_n = 0;
    logic        exp_done = 1'b0;
    logic        exp_err = 1'b0;

    bit   mon_en = 1'b0;
    bit   pend_acc = 1'b0;
    bit   pend_rst = 1'b0;
    int   acc_pos = 0;
    int   mon_p;
    logic mon_we_exp;

    // A write must appear exactly in the cycle after the 4th byte of each data word.
    always begin
        @(negedge clk);
        if (mon_en) begin
            mon_we_exp = 1'b0;
            if (pend_rst) begin
                acc_pos = 0;
            end else if (pend_acc) begin
                mon_p = acc_pos - 2;
                if (mon_p >= 0 && mon_p < 4 * exp_n && (mon_p % 4) == 3) mon_we_exp = 1'b1;
                acc_pos++;
            end
            checks++;
            if (we !== mon_we_exp) begin
                errors++;
                $display("[TB] FAIL we_timing: got %b expected %b (stream byte %0d)", we, mon_we_exp, acc_pos);
            end
            if (we === 1'b1) wr_log.push_back({addr, wdata});
        end
        #2;
        pend_acc = (in_valid === 1'b1) && (rdy === 1'b1) && (rstn === 1'b1);
        pend_rst = (rstn === 1'b0);
    end

    initial begin
        #3_000_000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic model_stream();
        int depth;
        int n;
        logic [7:0] x;
        depth = sel_small ? 4 : 1024;
        n = int'({stream[1], stream[0]});
        exp_wr.delete();
        if (n > depth) begin
            exp_n = 0; exp_done = 1'b0; exp_err = 1'b1;
            return;
        end
        x = 8'h00;
        for (int i = 0; i < 4 * n; i++) x = x ^ stream[2 + i];
        for (int k = 0; k < n; k++)
            exp_wr.push_back({10'(k), stream[2+4*k+3], stream[2+4*k+2], stream[2+4*k+1], stream[2+4*k]});
        exp_n    = n;
        exp_done = (stream[2 + 4 * n] == x);
        exp_err  = !exp_done;
    endtask

    task automatic make_image(input int n, input bit good);
        int depth;
        logic [7:0] x;
        logic [7:0] b;
        depth = sel_small ? 4 : 1024;
        stream.delete();
        stream.push_back(8'(n));
        stream.push_back(8'(n >> 8));
        if (n > depth) return;
        x = 8'h00;
        for (int i = 0; i < 4 * n; i++) begin
            b = 8'($urandom_range(255, 0));
            stream.push_back(b);
            x = x ^ b;
        end
        stream.push_back(good ? x : (x ^ 8'($urandom_range(255, 1))));
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        in_valid = 1'b0;
        repeat (2) begin @(negedge clk); #1; end
        rstn = 1'b1;
        @(negedge clk); #1;
        wr_log.delete();
    endtask

    task automatic push_byte(input logic [7:0] b, input int gap);
        int w;
        repeat (gap) begin
            in_valid = 1'b0;
            @(negedge clk); #1;
        end
        in_valid = 1'b1;
        in_data  = b;
        w = 0;
        while (rdy !== 1'b1 && w < 40) begin
            @(negedge clk); #1;
            w++;
        end
        if (w >= 40) begin
            checks++; errors++;
            $display("[TB] FAIL push_timeout: got in_ready=%b expected 1", rdy);
            in_valid = 1'b0;
            return;
        end
        @(negedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic send_stream(input int maxgap);
        foreach (stream[i]) push_byte(stream[i], $urandom_range(maxgap, 0));
    endtask

    task automatic check_result(input string name);
        checks++;
        if ({done, err, cpu, rdy} !== {exp_done, exp_err, exp_done, 1'b0}) begin
            errors++;
            $display("[TB] FAIL %s_status: got done/err/cpu/rdy=%b%b%b%b expected %b%b%b0",
                     name, done, err, cpu, rdy, exp_done, exp_err, exp_done);
        end
        repeat (3) begin @(negedge clk); #1; end
        checks++;
        if (wr_log.size() != exp_wr.size()) begin
            errors++;
            $display("[TB] FAIL %s_write_count: got %0d expected %0d", name, wr_log.size(), exp_wr.size());
        end else begin
            foreach (exp_wr[i]) begin
                checks++;
                if (wr_log[i] !== exp_wr[i]) begin
                    errors++;
                    $display("[TB] FAIL %s_write%0d: got addr %0d data %h expected addr %0d data %h",
                             name, i, wr_log[i][41:32], wr_log[i][31:0], exp_wr[i][41:32], exp_wr[i][31:0]);
                end
            end
        end
        checks++;
        if ({done, err, cpu} !== {exp_done, exp_err, exp_done}) begin
            errors++;
            $display("[TB] FAIL %s_sticky: got done/err/cpu=%b%b%b expected %b%b%b",
                     name, done, err, cpu, exp_done, exp_err, exp_done);
        end
    endtask

    task automatic run_stream(input string name, input int maxgap);
        do_reset();
        model_stream();
        send_stream(maxgap);
        check_result(name);
    endtask

    task automatic test_reset();
        sel_small = 1'b0;
        rstn = 1'b0;
        in_valid = 1'b0;
        repeat (3) begin @(negedge clk); #1; end
        mon_en = 1'b1;
        checks++;
        if ({rdy, we, cpu, done, err} !== 5'b0) begin
            errors++;
            $display("[TB] FAIL reset_flags: got rdy/we/cpu/done/err=%b%b%b%b%b expected 00000", rdy, we, cpu, done, err);
        end
        checks++;
        if (addr !== 10'd0) begin
            errors++;
            $display("[TB] FAIL reset_addr: got %0d expected 0", addr);
        end
        checks++;
        if (wdata !== 32'd0) begin
            errors++;
            $display("[TB] FAIL reset_wdata: got %h expected 0", wdata);
        end
        rstn = 1'b1;
        @(negedge clk); #1;
        checks++;
        if (rdy !== 1'b1) begin
            errors++;
            $display("[TB] FAIL reset_release_ready: got %b expected 1", rdy);
        end
        wr_log.delete();
    endtask

    task automatic test_basic();
        sel_small = 1'b0;
        stream = '{8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h37, 8'h00, 8'h00, 8'h00, 8'h24};
        run_stream("basic", 0);
    endtask

    task automatic test_bad_csum();
        sel_small = 1'b0;
        stream = '{8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h37, 8'h00, 8'h00, 8'h00, 8'h25};
        run_stream("bad_csum", 0);
    endtask

    task automatic test_zero_len();
        sel_small = 1'b0;
        stream = '{8'h00, 8'h00, 8'h00};
        run_stream("zero_len_ok", 0);
        stream = '{8'h00, 8'h00, 8'h01};
        run_stream("zero_len_bad", 0);
    endtask

    task automatic test_depth();
        sel_small = 1'b1;
        stream = '{8'h05, 8'h00};
        run_stream("oversize", 0);
        make_image(4, 1'b1);
        run_stream("full_depth", 0);
        sel_small = 1'b0;
    endtask

    task automatic test_gaps();
        sel_small = 1'b0;
        stream = '{8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h37, 8'h00, 8'h00, 8'h00, 8'h24};
        for (int r = 0; r < 3; r++) run_stream("gaps", 5);
    endtask

    task automatic test_abort();
        sel_small = 1'b0;
        stream = '{8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h37, 8'h00, 8'h00, 8'h00, 8'h24};
        do_reset();
        model_stream();
        for (int i = 0; i < 8; i++) push_byte(stream[i], 0);
        checks++;
        if (wr_log.size() != 1) begin
            errors++;
            $display("[TB] FAIL abort_partial_count: got %0d expected 1", wr_log.size());
        end else begin
            checks++;
            if (wr_log[0] !== exp_wr[0]) begin
                errors++;
                $display("[TB] FAIL abort_first_word: got %h expected %h", wr_log[0], exp_wr[0]);
            end
        end
        rstn = 1'b0;
        @(negedge clk); #1;
        rstn = 1'b1;
        @(negedge clk); #1;
        checks++;
        if ({cpu, done, err, wr_log.size() == 1} !== 4'b0001) begin
            errors++;
            $display("[TB] FAIL abort_after_reset: got cpu/done/err=%b%b%b writes=%0d expected 000 writes=1",
                     cpu, done, err, wr_log.size());
        end
        wr_log.delete();
        send_stream(0);
        check_result("abort_resend");
    endtask

    task automatic test_random();
        int n;
        bit good;
        for (int it = 0; it < 12; it++) begin
            sel_small = 1'($urandom_range(1, 0));
            n = $urandom_range(6, 0);
            good = ($urandom_range(3, 0) != 0);
            make_image(n, good);
            run_stream("random", 3);
        end
        sel_small = 1'b0;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_bad_csum();
        test_zero_len();
        test_depth();
        test_gaps();
        test_abort();
        test_random();
        test_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
